// File: rtl/lamp_conflict_monitor_if.sv
// Lamp drive bus shared by the phase controller, the conflict monitor and the lamp drivers.
interface lamp_conflict_monitor_if;
  logic [35:0] lamp_in;
  logic        fault_clr;
  logic [35:0] lamp_out;
  logic        fault;
  logic [1:0]  fault_code;
  logic [3:0]  fault_head;

  modport master (output lamp_in, fault_clr, input lamp_out, fault, fault_code, fault_head);
  modport slave  (input lamp_in, fault_clr, output lamp_out, fault, fault_code, fault_head);
endinterface

// File: rtl/lamp_conflict_monitor.sv
// Safety stage between phase controller and lamp drivers: passes lamps through, detects
// conflicts, invalid heads and short yellows, and forces flashing red on a latched fault.
module lamp_conflict_monitor #(
  parameter int MIN_YELLOW  = 5,
  parameter int FILTER      = 2,
  parameter int FLASH_HALF  = 8,
  parameter int RECOVER_CYC = 5
) (
  input  logic                     clk,
  input  logic                     reset_n,
  lamp_conflict_monitor_if.slave   bus
);
  localparam int          NH      = 12;
  localparam logic [2:0]  S_RED   = 3'b001;
  localparam logic [2:0]  S_YEL   = 3'b010;
  localparam logic [2:0]  S_GRN   = 3'b100;
  localparam logic [35:0] ALL_RED = {NH{S_RED}};
  localparam int          RCW     = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;
  localparam int          FCW     = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

  typedef enum logic [1:0] {ST_RECOVER, ST_NORMAL, ST_FAULT} state_t;

  state_t         state_q;
  logic [RCW-1:0] rec_cnt_q;
  logic [FCW-1:0] flash_cnt_q;
  logic           flash_q;
  logic [35:0]    lamp_out_q;
  logic           fault_q;
  logic [1:0]     code_q;
  logic [3:0]     head_q;
  logic [7:0]     conf_cnt_q, conf_cnt_d, inv_cnt_q, inv_cnt_d;

  logic [NH-1:0]  act_vec, inv_vec, tim_vec;
  logic [3:0]     grp_act;
  logic           raw_conf, raw_inv, conf_latch, inv_latch, tim_latch, any_latch, clear_go;
  logic [3:0]     inv_head, tim_head, latch_head;
  logic [1:0]     latch_code;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign clear_go = (state_q == ST_FAULT) && bus.fault_clr && !raw_conf && !raw_inv;

  // Per-head tracker: previous drive and saturating yellow-run length.
  generate
    for (genvar gi = 0; gi < NH; gi++) begin : g_head
      logic [2:0] cur;
      logic [2:0] prev_q;
      logic [7:0] yrun_q;

      assign cur         = bus.lamp_in[3*gi +: 3];
      assign act_vec[gi] = cur[2] | cur[1];
      assign inv_vec[gi] = !((cur == S_RED) || (cur == S_YEL) || (cur == S_GRN));
      assign tim_vec[gi] = (cur == S_RED) &&
                           ((prev_q == S_GRN) ||
                            ((prev_q == S_YEL) && (yrun_q < 8'(MIN_YELLOW))));

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          prev_q <= '0;
          yrun_q <= '0;
        end else if (clear_go) begin
          prev_q <= '0;
          yrun_q <= '0;
        end else begin
          prev_q <= cur;
          yrun_q <= (cur == S_YEL) ? sat_inc(yrun_q) : 8'd0;
        end
      end
    end
  endgenerate

  assign grp_act[0] = act_vec[0] | act_vec[1] | act_vec[6] | act_vec[7];
  assign grp_act[1] = act_vec[2] | act_vec[5];
  assign grp_act[2] = act_vec[3] | act_vec[4] | act_vec[9] | act_vec[10];
  assign grp_act[3] = act_vec[8] | act_vec[11];

  // More than one bit set means movements from different groups are live together.
  assign raw_conf = |(grp_act & (grp_act - 4'd1));
  assign raw_inv  = |inv_vec;

  always_comb begin
    inv_head = '0;
    tim_head = '0;
    for (int i = NH - 1; i >= 0; i--) begin
      if (inv_vec[i]) inv_head = 4'(i);
      if (tim_vec[i]) tim_head = 4'(i);
    end
  end

  always_comb begin
    conf_cnt_d = '0;
    inv_cnt_d  = '0;
    if (!clear_go) begin
      if (raw_conf) conf_cnt_d = sat_inc(conf_cnt_q);
      if (raw_inv)  inv_cnt_d  = sat_inc(inv_cnt_q);
    end
    conf_latch = raw_conf && (conf_cnt_q >= 8'(FILTER - 1));
    inv_latch  = raw_inv  && (inv_cnt_q  >= 8'(FILTER - 1));
    tim_latch  = |tim_vec;
    any_latch  = conf_latch | inv_latch | tim_latch;
  end

  always_comb begin
    latch_code = 2'd0;
    latch_head = 4'd0;
    if (conf_latch) begin
      latch_code = 2'd1;
      latch_head = 4'hF;
    end else if (inv_latch) begin
      latch_code = 2'd2;
      latch_head = inv_head;
    end else if (tim_latch) begin
      latch_code = 2'd3;
      latch_head = tim_head;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RECOVER;
      rec_cnt_q   <= '0;
      flash_cnt_q <= '0;
      flash_q     <= 1'b0;
      lamp_out_q  <= ALL_RED;
      fault_q     <= 1'b0;
      code_q      <= '0;
      head_q      <= '0;
      conf_cnt_q  <= '0;
      inv_cnt_q   <= '0;
    end else begin
      conf_cnt_q <= conf_cnt_d;
      inv_cnt_q  <= inv_cnt_d;
      case (state_q)
        ST_RECOVER, ST_NORMAL: begin
          if (any_latch) begin
            state_q     <= ST_FAULT;
            fault_q     <= 1'b1;
            code_q      <= latch_code;
            head_q      <= latch_head;
            flash_q     <= 1'b1;
            flash_cnt_q <= '0;
            lamp_out_q  <= ALL_RED;
          end else if (state_q == ST_NORMAL) begin
            lamp_out_q <= bus.lamp_in;
          end else if (rec_cnt_q == RCW'(RECOVER_CYC - 1)) begin
            // Last recovery cycle already forwards the live drive.
            state_q    <= ST_NORMAL;
            lamp_out_q <= bus.lamp_in;
          end else begin
            rec_cnt_q  <= rec_cnt_q + RCW'(1);
            lamp_out_q <= ALL_RED;
          end
        end
        ST_FAULT: begin
          if (clear_go) begin
            state_q    <= ST_RECOVER;
            rec_cnt_q  <= '0;
            fault_q    <= 1'b0;
            code_q     <= '0;
            head_q     <= '0;
            lamp_out_q <= ALL_RED;
          end else if (flash_cnt_q == FCW'(FLASH_HALF - 1)) begin
            flash_cnt_q <= '0;
            flash_q     <= ~flash_q;
            lamp_out_q  <= {NH{{2'b00, ~flash_q}}};
          end else begin
            flash_cnt_q <= flash_cnt_q + FCW'(1);
            lamp_out_q  <= {NH{{2'b00, flash_q}}};
          end
        end
        default: state_q <= ST_RECOVER;
      endcase
    end
  end

  assign bus.lamp_out   = lamp_out_q;
  assign bus.fault      = fault_q;
  assign bus.fault_code = code_q;
  assign bus.fault_head = head_q;
endmodule

// File: tb/tb_lamp_conflict_monitor.sv
// Directed scenarios plus randomized lamp traffic, checked every cycle against a behavioural model.
module tb_lamp_conflict_monitor;
  localparam int MIN_YELLOW  = 5;
  localparam int FILTER      = 2;
  localparam int FLASH_HALF  = 8;
  localparam int RECOVER_CYC = 5;
  localparam logic [2:0]  RED = 3'b001;
  localparam logic [2:0]  YEL = 3'b010;
  localparam logic [2:0]  GRN = 3'b100;
  localparam logic [35:0] ALL_RED = {12{3'b001}};

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  lamp_conflict_monitor_if bus ();

  lamp_conflict_monitor #(
    .MIN_YELLOW (MIN_YELLOW),
    .FILTER     (FILTER),
    .FLASH_HALF (FLASH_HALF),
    .RECOVER_CYC(RECOVER_CYC)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: mode 0 = recover, 1 = normal, 2 = fault; m_age counts edges spent in mode.
  int          m_mode, m_age, m_code, m_head, m_cf, m_if;
  bit          m_fault;
  logic [35:0] m_out;
  logic [2:0]  m_prev [12];
  int          m_yrun [12];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int head_grp(input int h);
    case (h)
      0, 1, 6, 7:   return 0;
      2, 5:         return 1;
      3, 4, 9, 10:  return 2;
      default:      return 3;
    endcase
  endfunction

  function automatic logic [35:0] with_head(input logic [35:0] v, input int h, input logic [2:0] s);
    logic [35:0] r;
    r = v;
    r[3*h +: 3] = s;
    return r;
  endfunction

  function automatic logic [35:0] grp_vec(input int g, input logic [2:0] s);
    logic [35:0] r;
    r = ALL_RED;
    for (int i = 0; i < 12; i++)
      if (head_grp(i) == g) r[3*i +: 3] = s;
    return r;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_age = 0; m_out = ALL_RED; m_fault = 0;
    m_code = 0; m_head = 0; m_cf = 0; m_if = 0;
    for (int i = 0; i < 12; i++) begin
      m_prev[i] = 3'b000;
      m_yrun[i] = 0;
    end
  endtask

  task automatic model_step(input logic [35:0] li, input bit clr);
    logic [2:0] hv;
    bit         groups [4];
    int         ngroups, ih, th;
    bit         conf, inv, conf_l, inv_l, tim, clear;
    ngroups = 0; ih = -1; th = -1;
    for (int g = 0; g < 4; g++) groups[g] = 0;
    for (int i = 0; i < 12; i++) begin
      hv = li[3*i +: 3];
      if (hv == GRN || hv[1]) groups[head_grp(i)] = 1;
      if ($countones(hv) != 1 && ih < 0) ih = i;
      if (hv == RED && th < 0 &&
          (m_prev[i] == GRN || (m_prev[i] == YEL && m_yrun[i] < MIN_YELLOW))) th = i;
    end
    for (int g = 0; g < 4; g++) ngroups += int'(groups[g]);
    // Any green bit counts as active as well, even in malformed head states.
    for (int i = 0; i < 12; i++) begin
      hv = li[3*i +: 3];
      if (hv[2] && !groups[head_grp(i)]) begin
        groups[head_grp(i)] = 1;
        ngroups++;
      end
    end
    conf = ngroups > 1;
    inv  = ih >= 0;
    tim  = th >= 0;
    m_cf = conf ? ((m_cf < 255) ? m_cf + 1 : 255) : 0;
    m_if = inv  ? ((m_if < 255) ? m_if + 1 : 255) : 0;
    conf_l = conf && m_cf >= FILTER;
    inv_l  = inv  && m_if >= FILTER;
    clear  = (m_mode == 2) && clr && !conf && !inv;
    for (int i = 0; i < 12; i++) begin
      hv = li[3*i +: 3];
      if (clear) begin
        m_prev[i] = 3'b000;
        m_yrun[i] = 0;
      end else begin
        m_yrun[i] = (hv == YEL) ? ((m_yrun[i] < 255) ? m_yrun[i] + 1 : 255) : 0;
        m_prev[i] = hv;
      end
    end
    if (clear) begin
      m_cf = 0;
      m_if = 0;
    end
    if (m_mode != 2 && (conf_l || inv_l || tim)) begin
      m_mode = 2; m_age = 0; m_fault = 1; m_out = ALL_RED;
      m_code = conf_l ? 1 : (inv_l ? 2 : 3);
      m_head = conf_l ? 15 : (inv_l ? ih : th);
    end else if (m_mode == 0) begin
      if (m_age + 1 >= RECOVER_CYC) begin
        m_mode = 1;
        m_out  = li;
      end else begin
        m_age++;
        m_out = ALL_RED;
      end
    end else if (m_mode == 1) begin
      m_out = li;
    end else if (clear) begin
      m_mode = 0; m_age = 0; m_fault = 0; m_code = 0; m_head = 0; m_out = ALL_RED;
    end else begin
      m_age++;
      m_out = (((m_age / FLASH_HALF) % 2) == 0) ? ALL_RED : 36'd0;
    end
  endtask

  // One clock: drive, let the edge pass, advance the model, compare shortly after the edge.
  task automatic cyc(input logic [35:0] li, input bit clr);
    bus.lamp_in   = li;
    bus.fault_clr = clr;
    @(posedge clk);
    model_step(li, clr);
    #1;
    check_eq("lamp_out", bus.lamp_out, m_out);
    check_eq("fault_info", {bus.fault, bus.fault_code, bus.fault_head},
             {m_fault, 2'(m_code), 4'(m_head)});
  endtask

  task automatic clear_and_recover();
    cyc(ALL_RED, 1'b1);
    check_eq("clear_fault", bus.fault, 1'b0);
    repeat (RECOVER_CYC) cyc(ALL_RED, 1'b0);
  endtask

  logic [35:0] conf_v, h1y, y0, cur_li;
  logic [63:0] rv;
  int          r;

  initial begin
    bus.lamp_in   = ALL_RED;
    bus.fault_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_lamp", bus.lamp_out, ALL_RED);
    check_eq("rst_info", {bus.fault, bus.fault_code, bus.fault_head}, 7'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Recovery then pass-through
    for (int k = 0; k < RECOVER_CYC - 1; k++) begin
      cyc(ALL_RED, 1'b0);
      check_eq("recover_red", bus.lamp_out, ALL_RED);
    end
    cyc(grp_vec(0, GRN), 1'b0);
    check_eq("first_pass", bus.lamp_out, grp_vec(0, GRN));
    $display("T1 recovery: %0d compared so far", n_cmp);

    // Legal full phase cycle
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 40; k++) begin
        cur_li = (k < 30) ? grp_vec(g, GRN) : ((k < 35) ? grp_vec(g, YEL) : ALL_RED);
        cyc(cur_li, 1'b0);
        check_eq("passthru", bus.lamp_out, cur_li);
      end
    end
    check_eq("legal_nofault", bus.fault, 1'b0);
    $display("T2 legal cycle: %0d compared so far", n_cmp);

    // Single-cycle conflict is filtered out
    repeat (2) cyc(with_head(ALL_RED, 1, GRN), 1'b0);
    h1y = with_head(ALL_RED, 1, YEL);
    repeat (5) cyc(h1y, 1'b0);
    cyc(with_head(h1y, 4, GRN), 1'b0);
    repeat (5) cyc(with_head(ALL_RED, 4, YEL), 1'b0);
    cyc(ALL_RED, 1'b0);
    check_eq("glitch_nofault", bus.fault, 1'b0);
    $display("T3a one-cycle conflict: %0d compared so far", n_cmp);

    // Persistent conflict latches and flashes
    conf_v = with_head(with_head(ALL_RED, 1, GRN), 4, GRN);
    cyc(conf_v, 1'b0);
    check_eq("conf_wait", bus.fault, 1'b0);
    cyc(conf_v, 1'b0);
    check_eq("conf_info", {bus.fault, bus.fault_code, bus.fault_head}, {1'b1, 2'd1, 4'hF});
    check_eq("conf_red", bus.lamp_out, ALL_RED);
    for (int k = 1; k <= 20; k++) begin
      cyc(conf_v, 1'b0);
      if (k == 7)  check_eq("flash_on7", bus.lamp_out, ALL_RED);
      if (k == 8)  check_eq("flash_off8", bus.lamp_out, 36'd0);
      if (k == 16) check_eq("flash_on16", bus.lamp_out, ALL_RED);
    end
    $display("T3b conflict flash: %0d compared so far", n_cmp);

    // Clear refused while conflict persists, accepted once removed
    cyc(conf_v, 1'b1);
    check_eq("clr_refused", {bus.fault, bus.fault_code, bus.fault_head}, {1'b1, 2'd1, 4'hF});
    cyc(ALL_RED, 1'b0);
    check_eq("late_viol_code", bus.fault_code, 2'd1);
    cyc(ALL_RED, 1'b1);
    check_eq("clr_ok", bus.fault, 1'b0);
    for (int k = 0; k < RECOVER_CYC - 1; k++) begin
      cyc(ALL_RED, 1'b0);
      check_eq("post_clr_red", bus.lamp_out, ALL_RED);
    end
    y0 = with_head(ALL_RED, 0, YEL);
    cyc(y0, 1'b0);
    check_eq("post_clr_pass", bus.lamp_out, y0);
    repeat (5) cyc(y0, 1'b0);
    cyc(ALL_RED, 1'b0);
    $display("T5 clear: %0d compared so far", n_cmp);

    // Invalid head and yellow timing faults
    cyc(with_head(ALL_RED, 7, 3'b011), 1'b0);
    check_eq("inv_wait", bus.fault, 1'b0);
    cyc(with_head(ALL_RED, 7, 3'b011), 1'b0);
    check_eq("inv_info", {bus.fault, bus.fault_code, bus.fault_head}, {1'b1, 2'd2, 4'd7});
    clear_and_recover();
    repeat (3) cyc(with_head(ALL_RED, 2, GRN), 1'b0);
    cyc(ALL_RED, 1'b0);
    check_eq("g2r_info", {bus.fault, bus.fault_code, bus.fault_head}, {1'b1, 2'd3, 4'd2});
    clear_and_recover();
    repeat (4) cyc(with_head(ALL_RED, 3, YEL), 1'b0);
    cyc(ALL_RED, 1'b0);
    check_eq("short_y_info", {bus.fault, bus.fault_code, bus.fault_head}, {1'b1, 2'd3, 4'd3});
    clear_and_recover();
    $display("T4 invalid/timing: %0d compared so far", n_cmp);

    // Asynchronous reset in the dark half of a flash
    repeat (2) cyc(conf_v, 1'b0);
    repeat (10) cyc(conf_v, 1'b0);
    check_eq("pre_rst_dark", bus.lamp_out, 36'd0);
    bus.lamp_in = ALL_RED;
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_lamp", bus.lamp_out, ALL_RED);
    check_eq("async_rst_fault", bus.fault, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    $display("T6 async reset: %0d compared so far", n_cmp);

    // Randomized traffic
    cur_li = ALL_RED;
    for (int b = 0; b < 15; b++) begin
      for (int k = 0; k < 100; k++) begin
        r = $urandom_range(99);
        if (r < 10) begin
          rv = {$urandom(), $urandom()};
          cur_li = rv[35:0];
        end else if (r < 60) begin
          cur_li = cur_li;
        end else if (r < 90) begin
          cur_li = grp_vec($urandom_range(3), ($urandom_range(1) == 0) ? GRN : YEL);
        end else begin
          cur_li = ALL_RED;
        end
        cyc(cur_li, $urandom_range(9) == 0);
      end
      $display("R%0d random burst: %0d compared, %0d mismatched so far", b, n_cmp, n_err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
